// File: rtl/ps2_host_ctrl.sv
// PS/2 host-to-device command sequencer: inhibits the bus, requests to send,
// shifts one command frame out on device clocks and waits for the 0xFA/0xFE reply.
module ps2_host_ctrl #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_block,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] status
);

  // Handshake: a command transfers on a rising clock edge where cmd_valid and
  // cmd_ready are both 1; cmd_ready is high only in IDLE, so cmd_data is never
  // looked at while a command is in flight.

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACKBIT,
    S_WAIT_ACK
  } state_t;

  localparam int INH_W = (INHIBIT_CYCLES < 2) ? 1 : $clog2(INHIBIT_CYCLES);
  localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  localparam logic [1:0] ST_OK    = 2'd0;
  localparam logic [1:0] ST_RETRY = 2'd1;
  localparam logic [1:0] ST_TMO   = 2'd2;

  state_t           state;
  logic [2:0]       clk_s;
  logic [1:0]       dat_s;
  logic             fall;
  logic [9:0]       frame;
  logic [3:0]       idx;
  logic [INH_W-1:0] inh_cnt;
  logic [TMO_W-1:0] tmo;
  logic [RTY_W-1:0] retry;
  logic             tmo_state;
  logic             tmo_hit;
  logic             resend_req;

  // Pad synchronisers carry no reset; they only need a few cycles to settle.
  always_ff @(posedge clock) begin
    clk_s <= {clk_s[1:0], ps2_clk_i};
    dat_s <= {dat_s[0], ps2_dat_i};
  end

  assign fall = clk_s[2] & ~clk_s[1];

  assign tmo_state = (state == S_RTS) || (state == S_SEND) ||
                     (state == S_ACKBIT) || (state == S_WAIT_ACK);
  assign tmo_hit   = tmo_state && (tmo == TMO_LAST);

  // A high ACK bit and a 0xFE reply both mean "send that frame again".
  always_comb begin
    resend_req = 1'b0;
    if (state == S_ACKBIT && fall && dat_s[1])
      resend_req = 1'b1;
    if (state == S_WAIT_ACK && rx_valid && rx_data == 8'hFE)
      resend_req = 1'b1;
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rx_block  = (state == S_INHIBIT) || (state == S_RTS) ||
                     (state == S_SEND) || (state == S_ACKBIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      status     <= ST_OK;
      retry      <= '0;
      frame      <= '0;
      idx        <= '0;
      inh_cnt    <= '0;
      tmo        <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (tmo_state)
        tmo <= fall ? '0 : tmo + 1'b1;

      if (resend_req) begin
        if (retry < RTY_MAX) begin
          retry      <= retry + 1'b1;
          inh_cnt    <= INH_LOAD;
          ps2_clk_oe <= 1'b1;
          ps2_dat_oe <= 1'b0;
          state      <= S_INHIBIT;
        end else begin
          error      <= 1'b1;
          status     <= ST_RETRY;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          state      <= S_IDLE;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_valid) begin
              frame      <= {1'b1, ~^cmd_data, cmd_data};
              retry      <= '0;
              inh_cnt    <= INH_LOAD;
              ps2_clk_oe <= 1'b1;
              ps2_dat_oe <= 1'b0;
              state      <= S_INHIBIT;
            end
          end

          S_INHIBIT: begin
            if (inh_cnt == '0) begin
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b1;
              tmo        <= '0;
              state      <= S_RTS;
            end else begin
              inh_cnt <= inh_cnt - 1'b1;
            end
          end

          S_RTS: begin
            if (fall) begin
              ps2_dat_oe <= ~frame[0];
              idx        <= 4'd1;
              tmo        <= '0;
              state      <= S_SEND;
            end else if (tmo_hit) begin
              error      <= 1'b1;
              status     <= ST_TMO;
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b0;
              state      <= S_IDLE;
            end
          end

          S_SEND: begin
            // The last bit driven is the stop bit, which releases the line.
            if (fall) begin
              ps2_dat_oe <= ~frame[idx];
              if (idx == 4'd9)
                state <= S_ACKBIT;
              else
                idx <= idx + 1'b1;
            end else if (tmo_hit) begin
              error      <= 1'b1;
              status     <= ST_TMO;
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b0;
              state      <= S_IDLE;
            end
          end

          S_ACKBIT: begin
            ps2_dat_oe <= 1'b0;
            if (fall) begin
              tmo   <= '0;
              state <= S_WAIT_ACK;
            end else if (tmo_hit) begin
              error      <= 1'b1;
              status     <= ST_TMO;
              ps2_clk_oe <= 1'b0;
              state      <= S_IDLE;
            end
          end

          S_WAIT_ACK: begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            if (rx_valid && rx_data == 8'hFA) begin
              done   <= 1'b1;
              status <= ST_OK;
              state  <= S_IDLE;
            end else if (tmo_hit) begin
              error  <= 1'b1;
              status <= ST_TMO;
              state  <= S_IDLE;
            end
          end

          default: begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            state      <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: a device model clocks frames out, a reference model
// predicts frames and outcomes per command, and monitors compare what appears.
module tb_ps2_host_ctrl;

  localparam int INH  = 16;
  localparam int TMO  = 200;
  localparam int MAXR = 2;

  localparam int K_FA    = 0;
  localparam int K_FE    = 1;
  localparam int K_NACK  = 2;
  localparam int K_NOCLK = 3;

  // {done, error, status, cmd_ready, busy} seen on a result pulse
  localparam logic [5:0] R_DONE  = 6'b100010;
  localparam logic [5:0] R_RETRY = 6'b010110;
  localparam logic [5:0] R_TMO   = 6'b011010;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic       ps2_clk_i, ps2_dat_i;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_block, busy, done, error;
  logic [1:0] status;

  logic dev_clk = 1'b1;
  logic dev_dat_low = 1'b0;

  assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_i = ~dev_dat_low & ~ps2_dat_oe;

  int checks = 0;
  int errors = 0;
  int res_seen = 0;

  logic [9:0] exp_q[$];
  logic [5:0] exp_res_q[$];
  int         scr[$];

  ps2_host_ctrl #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .MAX_RETRY(MAXR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data(cmd_data),
    .ps2_clk_i(ps2_clk_i),
    .ps2_dat_i(ps2_dat_i),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_block(rx_block),
    .busy(busy),
    .done(done),
    .error(error),
    .status(status)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog simulation exceeded its time limit");
    $fatal(1);
  end

  // Reference model
  function automatic logic [9:0] make_frame(input logic [7:0] c);
    int   ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(c[i]);
    par = (ones % 2 == 0);
    return {1'b1, par, c};
  endfunction

  task automatic model_cmd(input logic [7:0] c, output int n);
    n = 0;
    foreach (scr[i]) begin
      n++;
      if (scr[i] == K_NOCLK) begin
        exp_res_q.push_back(R_TMO);
        return;
      end
      exp_q.push_back(make_frame(c));
      if (scr[i] == K_FA) begin
        exp_res_q.push_back(R_DONE);
        return;
      end
      if (n > MAXR) begin
        exp_res_q.push_back(R_RETRY);
        return;
      end
    end
  endtask

  // Monitors
  task automatic result_monitor();
    logic [5:0] got, exp;
    forever begin
      @(negedge clock);
      if (!reset && (done || error)) begin
        got = {done, error, status, cmd_ready, busy};
        res_seen++;
        checks++;
        if (exp_res_q.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected got=%b exp=none", got);
        end else begin
          exp = exp_res_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL result got=%b exp=%b (done,error,status,ready,busy)", got, exp);
          end
        end
      end
    end
  endtask

  task automatic inhibit_monitor();
    int   run;
    logic bad;
    run = 0;
    bad = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        run = 0;
        bad = 1'b0;
      end else if (ps2_clk_oe) begin
        run++;
        if (ps2_dat_oe) bad = 1'b1;
      end else if (run != 0) begin
        checks++;
        if (run != INH || bad) begin
          errors++;
          $display("FAIL inhibit_len got=%0d dat_oe_seen=%0b exp=%0d dat_oe_seen=0", run, bad, INH);
        end
        run = 0;
        bad = 1'b0;
      end
    end
  endtask

  // Driver tasks
  task automatic half();
    repeat ($urandom_range(6, 12)) @(negedge clock);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    int t;
    t = 0;
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_data  = c;
    while (!cmd_ready && t < 5000) begin
      @(negedge clock);
      t++;
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
  endtask

  task automatic wait_rts(output bit ok);
    int t;
    t = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && t < 2000) begin
      @(negedge clock);
      t++;
    end
    ok = (ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rts_wait got=no request-to-send exp=request-to-send within 2000 cycles");
    end
  endtask

  task automatic wait_result(input int r0);
    int t;
    t = 0;
    while (res_seen == r0 && t < 400) begin
      @(negedge clock);
      t++;
    end
    checks++;
    if (res_seen == r0) begin
      errors++;
      $display("FAIL result_wait got=none exp=done/error within 400 cycles");
    end
  endtask

  // Device model: one attempt, optionally cut short by a reset after 4 data bits
  task automatic dev_attempt(input int kind, input logic [7:0] c, input bit partial);
    logic [10:0] bits;
    logic [9:0]  ef;
    logic [8:0]  got9;
    logic [7:0]  b;
    bit          ok;
    int          n;
    bits = '0;
    wait_rts(ok);
    if (!ok) return;

    if (kind == K_NOCLK) begin
      n = 0;
      while (!error && n < 1000) begin
        @(negedge clock);
        n++;
      end
      checks++;
      if (n != TMO || {ps2_clk_oe, ps2_dat_oe, rx_block} != 3'b000) begin
        errors++;
        $display("FAIL timeout_timing got=%0d cycles oe/rx_block=%b exp=%0d cycles 000",
                 n, {ps2_clk_oe, ps2_dat_oe, rx_block}, TMO);
      end
      return;
    end

    bits[0] = ps2_dat_i;
    for (int k = 1; k <= (partial ? 4 : 10); k++) begin
      half();
      dev_clk = 1'b0;
      half();
      dev_clk = 1'b1;
      bits[k] = ps2_dat_i;
      if (k == 5 && $urandom_range(0, 1) == 1) rx_pulse(8'hFA);
    end

    if (partial) begin
      ef = make_frame(c);
      checks++;
      if (bits[4:0] !== {ef[3:0], 1'b0}) begin
        errors++;
        $display("FAIL partial_frame got=%b exp=%b", bits[4:0], {ef[3:0], 1'b0});
      end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      got9 = {ps2_clk_oe, ps2_dat_oe, cmd_ready, busy, done, error, status, rx_block};
      checks++;
      if (got9 !== 9'b001000000) begin
        errors++;
        $display("FAIL reset_mid got=%b exp=%b (clk_oe,dat_oe,ready,busy,done,error,status,rx_block)",
                 got9, 9'b001000000);
      end
      return;
    end

    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL frame_unexpected got=%b exp=none", bits);
    end else begin
      ef = exp_q.pop_front();
      if (bits !== {ef, 1'b0}) begin
        errors++;
        $display("FAIL frame got=%b exp=%b (stop..start)", bits, {ef, 1'b0});
      end
    end

    // ACK bit: device pulls data low before the 11th clock unless it refuses
    half();
    dev_dat_low = (kind != K_NACK);
    half();
    dev_clk = 1'b0;
    half();
    dev_clk = 1'b1;
    half();
    dev_dat_low = 1'b0;

    if (kind == K_FA || kind == K_FE) begin
      if ($urandom_range(0, 1) == 1) begin
        b = 8'($urandom);
        if (b == 8'hFA || b == 8'hFE) b = 8'h00;
        rx_pulse(b);
      end
      rx_pulse(kind == K_FA ? 8'hFA : 8'hFE);
    end
  endtask

  task automatic run_cmd(input logic [7:0] c);
    int n, r0;
    model_cmd(c, n);
    r0 = res_seen;
    send_cmd(c);
    for (int i = 0; i < n; i++) dev_attempt(scr[i], c, 1'b0);
    wait_result(r0);
  endtask

  // Main sequence
  initial begin
    logic [8:0] got9;
    logic [7:0] a, b;
    int         n, r0, k;

    fork
      result_monitor();
      inhibit_monitor();
    join_none

    repeat (3) @(negedge clock);
    got9 = {cmd_ready, busy, ps2_clk_oe, ps2_dat_oe, rx_block, done, error, status};
    checks++;
    if (got9 !== 9'b100000000) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", got9, 9'b100000000);
    end
    reset = 1'b0;
    repeat (4) @(negedge clock);

    rx_pulse(8'hFA);

    scr.delete(); scr.push_back(K_FA);
    run_cmd(8'hED);

    scr.delete(); scr.push_back(K_FE); scr.push_back(K_FE); scr.push_back(K_FA);
    run_cmd(8'hFF);

    scr.delete();
    for (int i = 0; i < 4; i++) scr.push_back(K_FE);
    run_cmd(8'hF3);

    scr.delete(); scr.push_back(K_NACK); scr.push_back(K_FA);
    run_cmd(8'h00);

    scr.delete(); scr.push_back(K_NOCLK);
    run_cmd(8'hF4);

    // Reset mid-frame with a second command held on cmd_valid the whole time
    a = 8'($urandom);
    b = 8'($urandom);
    r0 = res_seen;
    send_cmd(a);
    cmd_valid = 1'b1;
    cmd_data  = b;
    scr.delete(); scr.push_back(K_FA);
    model_cmd(b, n);
    dev_attempt(K_FA, a, 1'b1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    dev_attempt(K_FA, b, 1'b0);
    wait_result(r0);

    for (int t = 0; t < 10; t++) begin
      scr.delete();
      for (int j = 0; j < 4; j++) begin
        k = $urandom_range(0, 9);
        scr.push_back(k < 4 ? K_FA : (k < 7 ? K_FE : (k < 9 ? K_NACK : K_NOCLK)));
      end
      run_cmd(8'($urandom));
      repeat ($urandom_range(1, 10)) @(negedge clock);
    end

    repeat (20) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frames_left got=%0d exp=0", exp_q.size());
    end
    checks++;
    if (exp_res_q.size() != 0) begin
      errors++;
      $display("FAIL results_left got=%0d exp=0", exp_res_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_ctrl.md
Name: ps2_host_ctrl

Overview:
Host-to-device command sequencer for the PS/2 port. It accepts one command byte at a time (e.g. 0xED set-LEDs, 0xFF reset), inhibits the bus, issues request-to-send, and shifts the byte out on device-generated clocks. It then checks the line ACK bit and waits for the device's 0xFA/0xFE reply from the existing PS/2 receive path. It sits beside the PS/2 receiver and drives open-drain enables for the pads.

Parameters:
INHIBIT_CYCLES, 5000, clock cycles ps2_clk is held low before request-to-send (100 us at 50 MHz).
TIMEOUT_CYCLES, 1000000, maximum cycles without progress before the command is aborted.
MAX_RETRY, 3, resends allowed after a 0xFE reply or a missing ACK bit.

Ports:
clock  in  1  system clock; everything in this block is synchronous to it.
reset  in  1  synchronous, active-high reset.
cmd_valid  in  1  command byte offered.
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready; equals (state==IDLE).
cmd_data  in  8  command byte.
ps2_clk_i  in  1  raw pad clock input.
ps2_dat_i  in  1  raw pad data input.
ps2_clk_oe  out  1  1 = pull ps2_clk low.
ps2_dat_oe  out  1  1 = pull ps2_dat low.
rx_valid  in  1  one-cycle pulse: receiver decoded a byte.
rx_data  in  8  decoded byte, valid with rx_valid.
rx_block  out  1  tells the receiver to discard bits while the host owns the bus.
busy  out  1  state != IDLE.
done  out  1  one-cycle pulse: command acknowledged with 0xFA.
error  out  1  one-cycle pulse: command abandoned.
status  out  2  result of last command, held until next done/error: 0 ok, 1 retries exhausted, 2 timeout.

Behaviour:
- Reset values: state IDLE, cmd_ready=1, all other outputs 0, retry count 0. Input synchronisers are not reset.
- Sync: ps2_clk_i passes through a 3-flop shift register. fall = s[2]&~s[1]. ps2_dat_i passes through a 2-flop synchroniser.
- Frame: on accept, latch f[9:0] = {1'b1 stop, ~^cmd_data odd parity, cmd_data}. The data byte is sent LSB first. Set retry=0.
- IDLE: on accept, go to INHIBIT and load the counter.
- INHIBIT: clk_oe=1, dat_oe=0 for exactly INHIBIT_CYCLES cycles. Then, in the same cycle, set dat_oe=1 (start bit), clk_oe=0, and go to RTS.
- RTS: clk_oe=0, dat_oe=1. Wait for a fall, then go to SEND with bit index 0.
- SEND: on entry, and on each subsequent fall, set dat_oe=~f[idx] and increment idx. After f[9] (stop, line released) is driven, go to ACKBIT.
- ACKBIT: dat_oe=0. On the next fall, sample the synced data.
  - Data 0: go to WAIT_ACK.
  - Data 1: treat as a resend request.
- WAIT_ACK: both oe=0.
  - rx_valid with 0xFA: pulse done, status=0, go to IDLE.
  - rx_valid with 0xFE: treat as a resend request.
  - Any other byte: ignore.
- Resend request: if retry<MAX_RETRY, increment retry and go to INHIBIT with the same frame. Otherwise pulse error, status=1, go to IDLE.
- Timeout counter:
  - Cleared on entering RTS, SEND, ACKBIT or WAIT_ACK, and on every fall.
  - If it reaches TIMEOUT_CYCLES in any of those states: pulse error, status=2, both oe=0, go to IDLE.
- rx_block=1 in INHIBIT, RTS, SEND and ACKBIT; 0 in IDLE and WAIT_ACK.
- rx_valid outside WAIT_ACK is ignored.
- cmd_valid while busy: not accepted, cmd_data not sampled.
- done and error never assert in the same cycle. The next command can be accepted in the cycle after done/error.
- Reset mid-operation: on the next edge both oe=0, state IDLE, retry=0, status=0. The command is dropped with no done/error pulse.
- Latency: a pad clock falling edge affects dat_oe 3 clock cycles later. Device clock periods are at least 60 us, so this is within setup.

Test Plan:
1. INHIBIT_CYCLES=16; send 0xED. The device model clocks 11 edges, drives the ACK bit low, then sends rx 0xFA.
   -> clk_oe high exactly 16 cycles.
   -> Line values at device rising edges: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1.
   -> One done pulse, status=0, cmd_ready returns to 1.
2. Device replies 0xFE, 0xFE, 0xFA -> three identical frames each preceded by INHIBIT; done, status=0.
3. MAX_RETRY=2; device replies 0xFE four times -> three frames sent, then one error pulse, status=1, no done.
4. Device leaves ACK bit high at the 11th edge -> handled as a resend (a second frame appears); a second pass with ACK low plus 0xFA gives done.
5. TIMEOUT_CYCLES=200; device never clocks after RTS -> error pulse exactly 200 cycles after RTS entry, status=2, both oe=0, rx_block=0.
6. Assert reset for 1 cycle after 4 data bits; hold cmd_valid high during busy -> oe both 0 the next cycle, no done/error, cmd_ready=1; the command offered during busy is not accepted until IDLE.
